// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the up/down modulus counter
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Divider register width; a divide-by-1 still keeps a one-bit register.
    function automatic int presc_width(input int p);
        int w;
        w = $clog2(p);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - enable divider producing one tick per PRESCALE enabled cycles
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] div_q;
    logic [PW-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (enable) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // With PRESCALE=1 LAST is 0 and div_q never leaves 0, so tick follows enable.
    assign tick = enable && (div_q == LAST);

endmodule

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down counter over 0..limit with wrap/saturate, clear, load and prescaler
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int N        = 8,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_value,
    input  logic         up_down,
    input  logic [N-1:0] limit,
    input  logic         sat_mode,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         at_max,
    output logic         at_zero
);

    logic         tick;
    logic [N-1:0] count_q;
    logic [N-1:0] count_d;
    logic         tc_q;
    logic         tc_d;

    counter_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .clear (clear || load),
        .tick  (tick)
    );

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (tick) begin
            if (up_down == DIR_UP) begin
                // >= so a count left above a lowered limit still hits the boundary
                if (count_q >= limit) begin
                    tc_d    = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? limit : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (sat_mode == MODE_SAT) ? '0 : limit;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign at_max  = (count_q == limit);
    assign at_zero = (count_q == '0);

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's simple enable-gated counter. Adds: width N, runtime modulus (limit), up/down direction, synchronous clear and parallel load, wrap or saturate mode, built-in prescaler, and boundary/terminal-count flags.
- Used as a general-purpose event/timebase counter feeding timers and sequencers.

Parameters:
N, 8, counter width in bits (N >= 2)
PRESCALE, 1, clock-enable divider: one count step per PRESCALE enabled cycles (PRESCALE >= 1; 1 = step every enabled cycle)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  counting enable; prescaler advances only while high
clear  input  1  synchronous clear of count and prescaler
load  input  1  synchronous parallel load
load_value  input  N  value written to count on load
up_down  input  1  1 = count up, 0 = count down
limit  input  N  terminal value; count range is 0..limit
sat_mode  input  1  0 = wrap at boundary, 1 = saturate at boundary
count  output  N  current count (registered)
tc  output  1  registered one-cycle pulse on a boundary step
at_max  output  1  combinational: count == limit
at_zero  output  1  combinational: count == 0

Behaviour:
- Clock and reset: one clock, asynchronous active-high reset. Reset forces count=0, tc=0, prescaler=0 immediately, independent of clk.
- Priority per rising edge: reset > clear > load > step.
- clear: count<=0, prescaler<=0, tc<=0. Ignores enable.
- load: count<=load_value, prescaler<=0, tc<=0. Ignores enable.
  - A load_value greater than limit is accepted as-is.
- Prescaler:
  - Internal counter of width max(1, clog2(PRESCALE)). Advances only when enable=1; tick asserts when it reaches PRESCALE-1, then returns to 0.
  - With PRESCALE=1, tick = enable.
  - Holds its value when enable=0.
- Step occurs on an edge with tick=1 and no clear/load:
  - Up, count < limit: count<=count+1.
  - Up, count >= limit, wrap mode: count<=0, tc<=1.
  - Up, count >= limit, saturate mode: count<=limit, tc<=1.
  - Down, count > 0: count<=count-1.
  - Down, count == 0, wrap mode: count<=limit, tc<=1.
  - Down, count == 0, saturate mode: count holds 0, tc<=1.
  - Down while count > limit: plain decrement, no clamp.
- tc: high exactly one cycle after each boundary step; low on every other edge. In saturate mode, tc pulses on every tick attempted at the boundary.
- limit == 0:
  - Wrap mode: every tick gives count=0 and tc=1.
  - Saturate mode: count stays 0 and tc=1 per tick.
- Dynamic changes:
  - limit, up_down and sat_mode may change on any cycle and take effect at the next step.
  - Lowering limit below count causes the next up step to wrap or clamp.
- Width: all arithmetic is modulo 2^N. No carry-out is exposed.
- Reset mid-count: state is lost. The first step after reset release needs a full PRESCALE enabled cycles.

Decomposition:
- Shared package counter_pkg:
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1
  - function for prescaler width max(1, clog2(P))
- One sub-module, counter_prescaler:
  - parameter PRESCALE; ports clk, reset, enable, clear (clear or load), tick.
  - Top level instantiates it plus the count/tc register logic.

Test Plan:
- N=4, PRESCALE=1, limit=9, wrap, up, enable=1 from reset -> count 0,1,..,9,0; tc high only on the cycle count shows 0 after 9; at_max high when count=9.
- Same config, sat_mode=1 -> count reaches 9 and holds; tc pulses every cycle while held; up_down=0 then counts 8,7,..,0, holds 0 with tc pulsing.
- Down wrap, limit=5, count=0 -> next step count=5, tc=1; load load_value=12 (>limit) then up step -> count=0, tc=1.
- PRESCALE=3, enable toggled 1,1,0,1 -> one step only after third enabled cycle (count 0->1 on 4th edge); clear mid-prescale restarts the divider.
- Simultaneous clear+load+tick -> count=0, tc=0. Load+tick -> count=load_value, no step.
- Assert reset asynchronously between edges with count=7 -> count=0 and tc=0 before the next edge. Release -> counting resumes from 0.
